// File: rtl/fios_seq_pkg.sv
// Shared types and encodings for the FIOS PE sequencer: FSM states, PE mux
// selects, DSP opmodes and the registered PE control bundle.
package fios_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        AB0,
        WAIT_M,
        MUL_M,
        WAIT_P,
        ABJ,
        MPJ,
        DRAIN
    } seq_state_e;

    localparam logic [8:0] OPM_ZERO  = 9'h000;
    localparam logic [8:0] OPM_MUL   = 9'h005;
    localparam logic [8:0] OPM_MAC_C = 9'h035;

    // A/B operand selects: a*b word product, m computation, m*p accumulation
    localparam logic [1:0] SEL_AB    = 2'd0;
    localparam logic [1:0] SEL_MUL_M = 2'd1;
    localparam logic [1:0] SEL_MP    = 2'd2;

    // C operand selects: running accumulator vs delayed result word
    localparam logic [1:0] SEL_C_ACC = 2'd0;
    localparam logic [1:0] SEL_C_RES = 2'd1;

    typedef struct packed {
        logic       a_reg_en;
        logic       m_reg_en;
        logic       creg_en;
        logic       res_delay_en;
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
        logic [1:0] mux_c_sel;
        logic [8:0] opmode;
    } pe_ctrl_t;

    function automatic int unsigned dsp_latency(input int unsigned abreg, input int unsigned mreg);
        return 1 + abreg + mreg;
    endfunction

endpackage

// File: rtl/fios_seq_counter.sv
// Loadable wrapping index counter with a terminal-count flag at MAX_VAL.
module fios_seq_counter #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned MAX_VAL = 7
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_c
);

    logic [WIDTH-1:0] count_d, count_q;

    assign tc_c = (count_q == WIDTH'(MAX_VAL));

    // Load wins over increment; increment wraps to zero after the terminal value
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i) begin
            count_d = tc_c ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fios_pe_sequencer.sv
// FIOS Montgomery PE sequencer: walks a over i, b/p over j, driving registered PE controls.
// Optional FIOS_SEQ_CYCLE_COUNT_EN adds cycle_count_o (busy-cycle counter).
module fios_pe_sequencer
    import fios_seq_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 17,
    parameter int unsigned NUM_WORDS  = 8,
    parameter int unsigned ABREG      = 1,
    parameter int unsigned MREG       = 1
) (
    input  logic                         clock_i,
    input  logic                         reset_n_i,
    input  logic                         start_i,
    output logic                         busy_o,
    output logic                         done_o,
`ifdef FIOS_SEQ_CYCLE_COUNT_EN
    output logic [31:0]                  cycle_count_o,
`endif
    output logic [$clog2(NUM_WORDS)-1:0] a_idx_o,
    output logic [$clog2(NUM_WORDS)-1:0] word_idx_o,
    output logic                         a_reg_en_o,
    output logic                         m_reg_en_o,
    output logic                         CREG_en_o,
    output logic                         RES_delay_en_o,
    output logic [1:0]                   mux_A_sel_o,
    output logic [1:0]                   mux_B_sel_o,
    output logic [1:0]                   mux_C_sel_o,
    output logic [8:0]                   OPMODE_o
);

    localparam int unsigned IDX_W   = $clog2(NUM_WORDS);
    localparam int unsigned L       = dsp_latency(ABREG, MREG);
    localparam int unsigned PH_W    = $clog2(L + 1);
    localparam int unsigned WM_LAST = (L > 1) ? L - 2 : 0;

    if (WORD_WIDTH == 0 || NUM_WORDS < 2 || NUM_WORDS > 64) begin : g_param_check
        $error("fios_pe_sequencer: illegal WORD_WIDTH/NUM_WORDS");
    end

    seq_state_e       state_d, state_q;
    logic [PH_W-1:0]  phase_d, phase_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    pe_ctrl_t         ctrl_d, ctrl_q;
    logic [IDX_W-1:0] a_idx_d, a_idx_q;
    logic [IDX_W-1:0] word_idx_d, word_idx_q;

    logic             accept_c;
    logic             i_load, i_inc, i_tc;
    logic             j_load, j_inc, j_tc;
    logic [IDX_W-1:0] j_load_val;
    logic [IDX_W-1:0] i_cnt, j_cnt;

    fios_seq_counter #(.WIDTH(IDX_W), .MAX_VAL(NUM_WORDS - 1)) u_i_cnt (
        .clock_i    (clock_i),
        .reset_n_i  (reset_n_i),
        .load_i     (i_load),
        .load_val_i ('0),
        .inc_i      (i_inc),
        .count_o    (i_cnt),
        .tc_c       (i_tc)
    );

    fios_seq_counter #(.WIDTH(IDX_W), .MAX_VAL(NUM_WORDS - 1)) u_j_cnt (
        .clock_i    (clock_i),
        .reset_n_i  (reset_n_i),
        .load_i     (j_load),
        .load_val_i (j_load_val),
        .inc_i      (j_inc),
        .count_o    (j_cnt),
        .tc_c       (j_tc)
    );

    assign accept_c = (state_q == IDLE) && !busy_q && start_i;

    // Next state plus PE controls decoded from the current state, registered for the PE
    always_comb begin
        state_d       = state_q;
        phase_d       = '0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        ctrl_d        = '0;
        ctrl_d.opmode = OPM_ZERO;
        a_idx_d       = '0;
        word_idx_d    = '0;
        i_load        = 1'b0;
        i_inc         = 1'b0;
        j_load        = 1'b0;
        j_load_val    = '0;
        j_inc         = 1'b0;

        case (state_q)
            IDLE: begin
                // busy still set here means the drain just finished: retire first
                if (busy_q) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else if (start_i) begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                    i_load  = 1'b1;
                end
            end
            LOAD: begin
                ctrl_d.a_reg_en = 1'b1;
                a_idx_d         = i_cnt;
                j_load          = 1'b1;
                state_d         = AB0;
            end
            AB0: begin
                ctrl_d.opmode = OPM_MAC_C;
                word_idx_d    = j_cnt;
                state_d       = (L > 1) ? WAIT_M : MUL_M;
            end
            WAIT_M: begin
                if (phase_q == PH_W'(WM_LAST)) begin
                    state_d = MUL_M;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            MUL_M: begin
                ctrl_d.mux_a_sel = SEL_MUL_M;
                ctrl_d.mux_b_sel = SEL_MUL_M;
                ctrl_d.opmode    = OPM_MUL;
                state_d          = WAIT_P;
            end
            WAIT_P: begin
                if (phase_q == PH_W'(L - 1)) begin
                    ctrl_d.m_reg_en = 1'b1;
                    j_load          = 1'b1;
                    j_load_val      = IDX_W'(1);
                    state_d         = ABJ;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ABJ: begin
                ctrl_d.creg_en   = 1'b1;
                ctrl_d.mux_a_sel = SEL_AB;
                ctrl_d.mux_b_sel = SEL_AB;
                ctrl_d.mux_c_sel = SEL_C_ACC;
                ctrl_d.opmode    = OPM_MAC_C;
                word_idx_d       = j_cnt;
                j_inc            = 1'b1;
                if (j_tc) begin
                    state_d = MPJ;
                end
            end
            MPJ: begin
                ctrl_d.res_delay_en = 1'b1;
                ctrl_d.mux_a_sel    = SEL_MP;
                ctrl_d.mux_b_sel    = SEL_MP;
                ctrl_d.mux_c_sel    = SEL_C_RES;
                ctrl_d.opmode       = OPM_MAC_C;
                word_idx_d          = j_cnt;
                j_inc               = 1'b1;
                if (j_tc) begin
                    if (i_tc) begin
                        state_d = DRAIN;
                    end else begin
                        i_inc   = 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            DRAIN: begin
                if (phase_q == PH_W'(L - 1)) begin
                    state_d = IDLE;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ctrl_q     <= '0;
            a_idx_q    <= '0;
            word_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ctrl_q     <= ctrl_d;
            a_idx_q    <= a_idx_d;
            word_idx_q <= word_idx_d;
        end
    end

`ifdef FIOS_SEQ_CYCLE_COUNT_EN
    logic [31:0] cycle_count_d, cycle_count_q;

    always_comb begin
        cycle_count_d = cycle_count_q;
        if (accept_c) begin
            cycle_count_d = '0;
        end else if (busy_q) begin
            cycle_count_d = cycle_count_q + 32'(1);
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cycle_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cycle_count_o = cycle_count_q;
`else
    logic unused_accept;
    assign unused_accept = accept_c;
`endif

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign a_idx_o        = a_idx_q;
    assign word_idx_o     = word_idx_q;
    assign a_reg_en_o     = ctrl_q.a_reg_en;
    assign m_reg_en_o     = ctrl_q.m_reg_en;
    assign CREG_en_o      = ctrl_q.creg_en;
    assign RES_delay_en_o = ctrl_q.res_delay_en;
    assign mux_A_sel_o    = ctrl_q.mux_a_sel;
    assign mux_B_sel_o    = ctrl_q.mux_b_sel;
    assign mux_C_sel_o    = ctrl_q.mux_c_sel;
    assign OPMODE_o       = ctrl_q.opmode;

endmodule

// File: doc/fios_pe_sequencer.md
FIOS_PE_SEQUENCER -- requirements
Module: fios_pe_sequencer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 17: PE data word width.
REQ-002 SHALL have parameter NUM_WORDS, default 8: operand length S in words, legal range 2..64.
REQ-003 SHALL have parameters ABREG, default 1, and MREG, default 1: PE register options. Derived constant L = 1+ABREG+MREG is the DSP latency.
REQ-004 SHALL have a port clock_i, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 SHALL have a port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have a port start_i, input, 1 bit: start request, sampled only in IDLE.
REQ-007 SHALL have a port busy_o, output, 1 bit: high from start acceptance until done_o.
REQ-008 SHALL have a port done_o, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have a port a_idx_o, output, clog2(S) bits: index i of the a word to present.
REQ-010 SHALL have a port word_idx_o, output, clog2(S) bits: index j of the b/p word to present.
REQ-011 SHALL have ports a_reg_en_o, m_reg_en_o, CREG_en_o and RES_delay_en_o, output, 1 bit each: PE enables.
REQ-012 SHALL have ports mux_A_sel_o, mux_B_sel_o and mux_C_sel_o, output, 2 bits each: PE mux selects.
REQ-013 SHALL have a port OPMODE_o, output, 9 bits: DSP opmode.

Function
REQ-014 All PE control outputs SHALL be registered and driven one cycle ahead of their use cycle, because the PE re-registers them.
REQ-015 States SHALL be IDLE, LOAD, AB0, WAIT_M, MUL_M, WAIT_P, ABJ, MPJ, DRAIN.
REQ-016 In IDLE, start_i=1 SHALL move to LOAD with i=0 and assert busy_o on the next cycle; start_i while busy SHALL be ignored.
REQ-017 In LOAD (1 cycle): a_reg_en_o=1 and a_idx_o=i.
REQ-018 In AB0 (1 cycle): A_sel=0, B_sel=0, C_sel=0, word_idx_o=0, OPMODE=OPM_MAC_C.
REQ-019 WAIT_M SHALL last L-1 cycles with OPMODE=OPM_ZERO; when L=1 it SHALL be skipped.
REQ-020 In MUL_M (1 cycle): A_sel=1, B_sel=1, OPMODE=OPM_MUL.
REQ-021 WAIT_P SHALL last L cycles; m_reg_en_o SHALL be 1 only on its last cycle.
REQ-022 ABJ SHALL run for j=1..S-1, one word per cycle: A_sel=0, B_sel=0, C_sel=0, OPMODE=OPM_MAC_C, CREG_en_o=1.
REQ-023 MPJ SHALL run for j=0..S-1: A_sel=2, B_sel=2, C_sel=1, OPMODE=OPM_MAC_C, RES_delay_en_o=1.
REQ-024 Iteration length SHALL be T = 2S+2L+1 cycles.
REQ-025 At the end of MPJ, if i<S-1 the block SHALL increment i and go to LOAD; otherwise it SHALL go to DRAIN.
REQ-026 DRAIN SHALL last L cycles, then pulse done_o, drop busy_o and return to IDLE.
REQ-027 done_o SHALL occur exactly S*T+L+1 cycles after the start_i acceptance edge.
REQ-028 The j counter SHALL wrap from S-1 to 0 at the ABJ-to-MPJ boundary without an idle cycle.
REQ-029 Outside active phases, all enables SHALL be 0, selects 0, and OPMODE=OPM_ZERO.

Reset
REQ-030 reset_n_i low SHALL force IDLE immediately, including mid-operation.
REQ-031 During reset, all outputs SHALL be 0 (OPMODE_o=OPM_ZERO=9'h000), and counters i and j SHALL be 0.
REQ-032 The first start after reset deassertion SHALL be accepted normally.

Configuration
REQ-033 With FIOS_SEQ_CYCLE_COUNT_EN defined, the block SHALL add output cycle_count_o [31:0]: cleared on start acceptance, incremented each busy cycle, and held after done.
REQ-034 Without FIOS_SEQ_CYCLE_COUNT_EN, the port and its counter SHALL be absent.

Structure
REQ-035 Package fios_seq_pkg SHALL hold the state enum, the select encodings, and OPM_ZERO=9'h000, OPM_MUL=9'h005 and OPM_MAC_C=9'h035.
REQ-036 The i/j counters SHALL be in a sub-module fios_seq_counter (load, increment, terminal-count flag), instantiated twice.

Verification
REQ-037 S=4, L=3, pulse start_i: done_o SHALL pulse 4*15+3+1=64 cycles later, and busy_o SHALL be high for exactly that window.
REQ-038 S=4, L=3: m_reg_en_o SHALL be high once per iteration, 2+2+3=7 cycles after LOAD; 4 pulses total.
REQ-039 S=4, L=1: WAIT_M SHALL be skipped, T SHALL be 11, and done_o SHALL pulse at 4*11+1+1=46.
REQ-040 word_idx_o during ABJ then MPJ SHALL read 1,2,3,0,1,2,3 with no gap.
REQ-041 start_i held high continuously SHALL launch one operation only; the next SHALL launch the cycle after IDLE is re-entered.
REQ-042 reset_n_i pulled low at cycle 20 of an operation SHALL zero all outputs asynchronously, and no done_o SHALL follow.
